// File: rtl/rx_nrzi_unstuff.sv
// rx_nrzi_unstuff -- USB-style receive path: NRZI decode, bit unstuffing and
// byte assembly, with a serial hand-off (data_bit/bit_valid/crc_init) to a
// downstream CRC-16.
//
// Ports
//   clk        : system clock, all state updates on its rising edge
//   n_rst      : synchronous active-low reset
//   d_line     : synchronized D+ sample, valid when bit_strobe is high
//   bit_strobe : one-cycle pulse at the bit centre
//   rx_enable  : high for the duration of a packet; low clears packet state
//   data_bit   : decoded, unstuffed bit (CRC serial input)
//   bit_valid  : one-cycle qualifier for data_bit (CRC shift enable)
//   crc_init   : CRC preset level, high while idle
//   byte_out   : assembled byte, first received bit ends up in bit 0
//   byte_valid : one-cycle pulse when byte_out holds a freshly completed byte
//   stuff_err  : sticky bit-stuffing violation flag, cleared on return to idle
//
// All outputs are registered; an accepted strobe shows up one clock later.

module rx_nrzi_unstuff #(
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   MAX_ONES   = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_line,
  input  logic       bit_strobe,
  input  logic       rx_enable,
  output logic       data_bit,
  output logic       bit_valid,
  output logic       crc_init,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       stuff_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [2:0] MAX_ONES_C = 3'(MAX_ONES);

  state_t     state, state_next;
  logic       prev_line, prev_line_next;
  logic [2:0] ones_cnt, ones_cnt_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] byte_out_next;
  logic       data_bit_next;
  logic       bit_valid_next;
  logic       byte_valid_next;
  logic       stuff_err_next;
  logic       crc_init_next;
  logic       decoded;

  // No line transition means a one, a transition means a zero.
  assign decoded = ~(d_line ^ prev_line);

  always_comb begin
    state_next      = state;
    prev_line_next  = prev_line;
    ones_cnt_next   = ones_cnt;
    bit_cnt_next    = bit_cnt;
    byte_out_next   = byte_out;
    data_bit_next   = 1'b0;
    bit_valid_next  = 1'b0;
    byte_valid_next = 1'b0;
    stuff_err_next  = stuff_err;

    if (!rx_enable) begin
      // Dropping enable ends the packet from any state; a partial byte is
      // discarded silently, but the last byte_out value is kept.
      state_next     = IDLE;
      prev_line_next = IDLE_LEVEL;
      ones_cnt_next  = 3'd0;
      bit_cnt_next   = 3'd0;
      stuff_err_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A strobe coinciding with the enable edge is not taken.
          state_next = RUN;
        end
        RUN: begin
          if (bit_strobe) begin
            prev_line_next = d_line;
            if (ones_cnt == MAX_ONES_C) begin
              if (decoded) begin
                // Too many ones in a row: the packet is corrupt.
                state_next     = ERROR;
                stuff_err_next = 1'b1;
              end else begin
                // Stuffed zero: drop it and restart the run count.
                ones_cnt_next = 3'd0;
              end
            end else begin
              ones_cnt_next   = decoded ? (ones_cnt + 3'd1) : 3'd0;
              data_bit_next   = decoded;
              bit_valid_next  = 1'b1;
              byte_out_next   = {decoded, byte_out[7:1]};
              bit_cnt_next    = bit_cnt + 3'd1;
              byte_valid_next = (bit_cnt == 3'd7);
            end
          end
        end
        ERROR: begin
          // Hold until rx_enable drops; strobes are ignored.
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    crc_init_next = (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      prev_line  <= IDLE_LEVEL;
      ones_cnt   <= 3'd0;
      bit_cnt    <= 3'd0;
      byte_out   <= 8'h00;
      data_bit   <= 1'b0;
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      stuff_err  <= 1'b0;
      crc_init   <= 1'b1;
    end else begin
      state      <= state_next;
      prev_line  <= prev_line_next;
      ones_cnt   <= ones_cnt_next;
      bit_cnt    <= bit_cnt_next;
      byte_out   <= byte_out_next;
      data_bit   <= data_bit_next;
      bit_valid  <= bit_valid_next;
      byte_valid <= byte_valid_next;
      stuff_err  <= stuff_err_next;
      crc_init   <= crc_init_next;
    end
  end

endmodule

// File: tb/tb_rx_nrzi_unstuff.sv
// Testbench for rx_nrzi_unstuff: directed scenarios plus randomized packets,
// every output compared each cycle against a packet-level model, with a
// bench-side CRC-16 fed from the serial hand-off outputs.

module tb_rx_nrzi_unstuff;

  localparam int MAX_ONES = 6;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_ERR  = 2;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_line;
  logic       bit_strobe;
  logic       rx_enable;
  logic       data_bit;
  logic       bit_valid;
  logic       crc_init;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       stuff_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rx_nrzi_unstuff #(
    .IDLE_LEVEL(1'b1),
    .MAX_ONES  (MAX_ONES)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_line    (d_line),
    .bit_strobe(bit_strobe),
    .rx_enable (rx_enable),
    .data_bit  (data_bit),
    .bit_valid (bit_valid),
    .crc_init  (crc_init),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .stuff_err (stuff_err)
  );

  // Downstream CRC-16 (preset to ones, LSB-first serial, reflected poly).
  logic [15:0] crc_tb;
  always @(posedge clk) begin
    if (crc_init === 1'b1)
      crc_tb <= 16'hFFFF;
    else if (bit_valid === 1'b1)
      crc_tb <= {1'b0, crc_tb[15:1]} ^ (((crc_tb[0] ^ data_bit) == 1'b1) ? 16'hA001 : 16'h0000);
  end

  // Packet-level model state.
  int         m_mode;
  logic       m_prev;
  int         m_run;        // current run length of decoded ones
  int         m_pkt_bits;   // bits delivered in this packet
  bit         hist[$];      // last delivered bits, newest at the back
  logic       e_data_bit, e_bit_valid, e_byte_valid, e_stuff_err, e_crc_init;
  logic [7:0] e_byte;

  int n_bv, n_byv;

  // Transmit-side encoder state.
  logic tx_level;
  int   tx_ones;
  logic lv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic en, input logic stb, input logic line);
    logic dec;
    e_data_bit   = 1'b0;
    e_bit_valid  = 1'b0;
    e_byte_valid = 1'b0;
    if (!r) begin
      m_mode = M_IDLE; m_prev = 1'b1; m_run = 0; m_pkt_bits = 0;
      hist.delete(); e_byte = 8'h00; e_stuff_err = 1'b0;
    end else if (!en) begin
      m_mode = M_IDLE; m_prev = 1'b1; m_run = 0; m_pkt_bits = 0;
      e_stuff_err = 1'b0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && stb) begin
      dec = (line == m_prev);
      m_prev = line;
      if (m_run == MAX_ONES) begin
        if (dec) begin
          m_mode = M_ERR;
          e_stuff_err = 1'b1;
        end else begin
          m_run = 0;
        end
      end else begin
        m_run = dec ? m_run + 1 : 0;
        e_bit_valid = 1'b1;
        e_data_bit  = dec;
        hist.push_back(dec);
        if (hist.size() > 8) void'(hist.pop_front());
        m_pkt_bits++;
        e_byte_valid = ((m_pkt_bits % 8) == 0);
        e_byte = 8'h00;
        for (int j = 0; j < hist.size(); j++)
          e_byte[7-j] = hist[hist.size()-1-j];
      end
    end
    e_crc_init = (m_mode == M_IDLE);
  endtask

  task automatic step(input logic r, input logic en, input logic stb, input logic line);
    @(negedge clk);
    n_rst = r; rx_enable = en; bit_strobe = stb; d_line = line;
    model_update(r, en, stb, line);
    @(posedge clk);
    #1;
    chk("data_bit",   32'(data_bit),   32'(e_data_bit));
    chk("bit_valid",  32'(bit_valid),  32'(e_bit_valid));
    chk("byte_valid", 32'(byte_valid), 32'(e_byte_valid));
    chk("byte_out",   32'(byte_out),   32'(e_byte));
    chk("stuff_err",  32'(stuff_err),  32'(e_stuff_err));
    chk("crc_init",   32'(crc_init),   32'(e_crc_init));
    if (bit_valid === 1'b1) n_bv++;
    if (byte_valid === 1'b1) begin
      n_byv++;
      $display("byte %02h at %0t", byte_out, $time);
    end
  endtask

  task automatic start_pkt();
    tx_level = 1'b1;
    tx_ones  = 0;
    lv.delete();
  endtask

  // NRZI-encode one byte LSB first, inserting a zero after MAX_ONES ones.
  task automatic enc_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        tx_ones++;
        lv.push_back(tx_level);
        if (tx_ones == MAX_ONES) begin
          tx_level = ~tx_level;
          lv.push_back(tx_level);
          tx_ones = 0;
        end
      end else begin
        tx_level = ~tx_level;
        lv.push_back(tx_level);
        tx_ones = 0;
      end
    end
  endtask

  task automatic send_lv(input int max_gap, input int max_n);
    int n;
    n = 0;
    while (lv.size() > 0 && n < max_n) begin
      repeat ($urandom_range(max_gap, 0)) step(1'b1, 1'b1, 1'b0, 1'($urandom));
      step(1'b1, 1'b1, 1'b1, lv.pop_front());
      n++;
    end
    lv.delete();
  endtask

  initial begin
    n_rst = 1'b0; rx_enable = 1'b0; bit_strobe = 1'b0; d_line = 1'b1;
    n_bv = 0; n_byv = 0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_byte_out", 32'(byte_out), 32'(8'h00));
    chk("rst_crc_init", 32'(crc_init), 1);
    chk("rst_stuff_err", 32'(stuff_err), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Enable and strobe together: that strobe is ignored; then SYNC.
    n_bv = 0; n_byv = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("same_cycle_bv", 32'(bit_valid), 0);
    chk("run_crc_init", 32'(crc_init), 0);
    start_pkt();
    enc_byte(8'h80);
    send_lv(2, 100);
    chk("sync_bv_cnt", n_bv, 8);
    chk("sync_byv_cnt", n_byv, 1);
    chk("sync_byte", 32'(byte_out), 32'(8'h80));

    // 0xFF after SYNC, with one stuffed zero on the line.
    n_bv = 0; n_byv = 0;
    enc_byte(8'hFF);
    chk("ff_line_len", lv.size(), 9);
    send_lv(1, 100);
    chk("ff_bv_cnt", n_bv, 8);
    chk("ff_byte", 32'(byte_out), 32'(8'hFF));
    chk("ff_stuff_err", 32'(stuff_err), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Stuff violation: seven strobes with no transition.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_bv = 0;
    repeat (7) step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("viol_bv_cnt", n_bv, 6);
    chk("viol_stuff_err", 32'(stuff_err), 1);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'($urandom));
    chk("viol_no_more_bv", n_bv, 6);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("viol_cleared", 32'(stuff_err), 0);

    // CRC hand-off for 0xCC, 0x33.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_bv = 0;
    start_pkt();
    enc_byte(8'hCC);
    enc_byte(8'h33);
    send_lv(1, 100);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("crc_bv_cnt", n_bv, 16);
    chk("crc_value", 32'(crc_tb), 32'(16'hA514));
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Abort by reset after three bits, then a clean SYNC.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_byv = 0;
    start_pkt();
    enc_byte(8'h80);
    send_lv(0, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("rstabort_crc_init", 32'(crc_init), 1);
    chk("rstabort_byv", n_byv, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    start_pkt();
    enc_byte(8'h80);
    send_lv(1, 100);
    chk("rstabort_next_byte", 32'(byte_out), 32'(8'h80));
    chk("rstabort_next_byv", n_byv, 1);

    // Abort by enable low after three bits, then a clean packet.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_byv = 0;
    start_pkt();
    enc_byte(8'h5A);
    send_lv(0, 3);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("enabort_crc_init", 32'(crc_init), 1);
    chk("enabort_byv", n_byv, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    start_pkt();
    enc_byte(8'h3C);
    send_lv(1, 100);
    chk("enabort_next_byte", 32'(byte_out), 32'(8'h3C));
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Randomized packets: gaps, back-to-back strobes, corruption, truncation.
    for (int p = 0; p < 40; p++) begin
      int mode;
      int nb;
      mode = int'($urandom_range(5, 0));
      if ($urandom_range(9, 0) == 0) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      step(1'b1, 1'b1, 1'($urandom), 1'($urandom));
      start_pkt();
      nb = int'($urandom_range(3, 1));
      for (int b = 0; b < nb; b++) enc_byte(8'($urandom));
      if (mode == 0) begin
        for (int k = 0; k < lv.size(); k++)
          if ($urandom_range(5, 0) == 0) lv[k] = 1'($urandom);
      end else if (mode == 1) begin
        for (int k = 0; k < 10; k++) lv.push_back(tx_level);
      end
      send_lv((mode == 2) ? 0 : 2, (mode == 3) ? int'($urandom_range(20, 1)) : 1000);
      repeat ($urandom_range(2, 0)) step(1'b1, 1'b1, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(2, 1)) step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
